// File: rtl/convcode_pkg.sv
// Shared definitions for the rate-1/2, K=3 (7,5) convolutional code and its Viterbi decoder.
package convcode_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 4;
    localparam logic [2:0]  G0         = 3'b111;
    localparam logic [2:0]  G1         = 3'b101;

    typedef struct packed {
        logic c0;
        logic c1;
    } code_pair_t;

    // Code pair emitted when bit b is shifted into state {b1,b2}.
    function automatic logic [1:0] expected_pair(input logic [1:0] state, input logic b);
        logic [2:0] r;
        r = {b, state};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to the even predecessor.
module viterbi_acs #(
    parameter int unsigned METRIC_W = 6
) (
    input  logic [METRIC_W-1:0] pm0,
    input  logic [METRIC_W-1:0] pm1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    output logic [METRIC_W-1:0] new_pm_c,
    output logic                dec_c
);

    localparam int unsigned SUM_W = METRIC_W + 1;

    logic [SUM_W-1:0] sum0_c;
    logic [SUM_W-1:0] sum1_c;

    assign sum0_c   = SUM_W'(pm0) + SUM_W'(bm0);
    assign sum1_c   = SUM_W'(pm1) + SUM_W'(bm1);
    assign dec_c    = (sum1_c < sum0_c);
    assign new_pm_c = dec_c ? METRIC_W'(sum1_c) : METRIC_W'(sum0_c);

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision 4-state Viterbi decoder with register-exchange survivors.
// Define VITERBI_METRIC_OUT_EN to add the best_metric channel-quality output.
module viterbi_decoder
    import convcode_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned METRIC_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                c0,
    input  logic                c1,
    output logic                out_valid,
    output logic                b_out
`ifdef VITERBI_METRIC_OUT_EN
    ,
    output logic [METRIC_W-1:0] best_metric
`endif
);

    localparam int unsigned   CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(2 ** (METRIC_W - 2));

    code_pair_t          rx_c;
    logic [METRIC_W-1:0] pm       [NUM_STATES];
    logic [METRIC_W-1:0] acs_pm_c [NUM_STATES];
    logic [METRIC_W-1:0] nrm_pm_c [NUM_STATES];
    logic                dec_c    [NUM_STATES];
    logic [1:0]          win_c    [NUM_STATES];
    logic [TB_DEPTH-1:0] surv     [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_nx_c[NUM_STATES];
    logic [CNT_W-1:0]    fill;
    logic [1:0]          best_c;
    logic [METRIC_W-1:0] min_c;
    logic                all_msb_c;

    assign rx_c = '{c0: c0, c1: c1};

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
        localparam logic [1:0] S  = 2'(s);
        localparam logic [1:0] P0 = {S[0], 1'b0};
        localparam logic [1:0] P1 = {S[0], 1'b1};

        viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
            .pm0      (pm[P0]),
            .pm1      (pm[P1]),
            .bm0      (hamming2(rx_c, expected_pair(P0, S[1]))),
            .bm1      (hamming2(rx_c, expected_pair(P1, S[1]))),
            .new_pm_c (acs_pm_c[s]),
            .dec_c    (dec_c[s])
        );

        assign win_c[s]     = {S[0], dec_c[s]};
        assign surv_nx_c[s] = {surv[win_c[s]][TB_DEPTH-2:0], S[1]};
        assign nrm_pm_c[s]  = all_msb_c ? {1'b0, acs_pm_c[s][METRIC_W-2:0]} : acs_pm_c[s];
    end

    // Shared MSB clear keeps the metrics bounded without changing their ordering.
    always_comb begin
        all_msb_c = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            all_msb_c = all_msb_c & acs_pm_c[i][METRIC_W-1];
        end
    end

    // Lowest pre-update metric; strict compare keeps ties on the lowest index.
    always_comb begin
        best_c = 2'd0;
        min_c  = pm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm[i] < min_c) begin
                min_c  = pm[i];
                best_c = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_INIT;
                surv[i] <= '0;
            end
            fill      <= '0;
            out_valid <= 1'b0;
            b_out     <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= nrm_pm_c[i];
                surv[i] <= surv_nx_c[i];
            end
            if (fill != CNT_W'(TB_DEPTH)) begin
                fill <= fill + CNT_W'(1);
            end
            out_valid <= (fill == CNT_W'(TB_DEPTH));
            b_out     <= surv[best_c][TB_DEPTH-1];
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef VITERBI_METRIC_OUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_metric <= '0;
        end else if (in_valid && (fill == CNT_W'(TB_DEPTH))) begin
            best_metric <= min_c;
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench: encodes source bits, feeds the decoder, expects the source delayed by 16 symbols.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int METRIC_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic c0 = 1'b0;
    logic c1 = 1'b0;
    logic out_valid;
    logic b_out;
`ifdef VITERBI_METRIC_OUT_EN
    logic [METRIC_W-1:0] best_metric;
`endif

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .METRIC_W(METRIC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .c0        (c0),
        .c1        (c1),
        .out_valid (out_valid),
        .b_out     (b_out)
`ifdef VITERBI_METRIC_OUT_EN
        ,
        .best_metric (best_metric)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    bit src[$];
    bit got[$];
    int first_at;
    int m[4];

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    // Reference encoder: shift register {b, b1, b2} masked by generators 7 and 5.
    function automatic bit [1:0] enc(input bit [1:0] st, input bit b);
        bit [2:0] r;
        r = {b, st};
        return {^(r & 3'b111), ^(r & 3'b101)};
    endfunction

    function automatic int hd(input bit [1:0] a, input bit [1:0] b);
        bit [1:0] d;
        d = a ^ b;
        return int'(d[1]) + int'(d[0]);
    endfunction

    // Unbounded-integer path metrics; only their differences are compared with the DUT.
    task automatic model_acs(input bit [1:0] pr);
        int nm[4];
        for (int s = 0; s < 4; s++) begin
            bit [1:0] sv;
            int a, b;
            sv = 2'(s);
            a  = m[{sv[0], 1'b0}] + hd(pr, enc({sv[0], 1'b0}, sv[1]));
            b  = m[{sv[0], 1'b1}] + hd(pr, enc({sv[0], 1'b1}, sv[1]));
            nm[s] = (b < a) ? b : a;
        end
        m = nm;
    endtask

    task automatic step(input bit v, input bit a, input bit b);
        @(negedge clk);
        in_valid = v;
        c0 = a;
        c1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_bout", 32'(b_out), 0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int corrupt_idx, input int flip_every, input bit toggle,
                              input bit chk_pm, input int stop_after);
        bit [1:0] st;
        bit [1:0] pr;
        int acc;
        logic last_b;
        st = 2'b00;
        acc = 0;
        got.delete();
        first_at = -1;
        m = '{0, 16, 16, 16};
        for (int i = 0; i < src.size() && i < stop_after; i++) begin
            pr = enc(st, src[i]);
            st = {src[i], st[1]};
            if (i == corrupt_idx) pr[1] = ~pr[1];
            if (flip_every > 0 && (i % flip_every) == flip_every - 1) begin
                int k;
                k = int'($urandom_range(1, 0));
                pr[k] = ~pr[k];
            end
            step(1'b1, pr[1], pr[0]);
            acc++;
            if (out_valid === 1'b1) begin
                got.push_back(b_out);
                if (first_at < 0) first_at = acc;
            end
            if (chk_pm) begin
                model_acs(pr);
                for (int s = 1; s < 4; s++) begin
                    check("pm_diff", 32'(int'(dut.pm[s]) - int'(dut.pm[0])), 32'(m[s] - m[0]));
                end
            end
            if (toggle) begin
                last_b = b_out;
                step(1'b0, 1'b0, 1'b0);
                check("idle_valid", 32'(out_valid), 0);
                check("idle_hold", 32'(b_out), 32'(last_b));
            end
        end
        step(1'b0, 1'b0, 1'b0);
        check("trail_valid", 32'(out_valid), 0);
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = src.size() - TB_DEPTH;
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        check({tag, "_first"}, 32'(first_at), 32'(TB_DEPTH + 1));
        for (int k = 0; k < n && k < got.size(); k++) begin
            check({tag, "_bit"}, 32'(got[k]), 32'(src[k]));
        end
    endtask

    task automatic load_basic();
        src.delete();
        src.push_back(1'b1);
        src.push_back(1'b0);
        src.push_back(1'b1);
        src.push_back(1'b1);
        for (int i = 0; i < 2 + TB_DEPTH; i++) src.push_back(1'b0);
    endtask

    initial begin
        // Idle after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle_rst_valid", 32'(out_valid), 0);
            check("idle_rst_bout", 32'(b_out), 0);
        end

        // Clean stream 1,0,1,1 + tail
        load_basic();
        run_stream(-1, 0, 1'b0, 1'b1, 1 << 30);
        check_stream("basic");

        // Third pair corrupted 00 -> 10
        do_reset();
        run_stream(2, 0, 1'b0, 1'b0, 1 << 30);
        check_stream("corrupt");

        // in_valid toggling
        do_reset();
        run_stream(-1, 0, 1'b1, 1'b0, 1 << 30);
        check_stream("toggle");

        // Reset mid-stream, then restart
        do_reset();
        run_stream(-1, 0, 1'b0, 1'b0, 10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_valid", 32'(out_valid), 0);
        check("mid_reset_bout", 32'(b_out), 0);
        @(negedge clk);
        reset = 1'b0;
        run_stream(-1, 0, 1'b0, 1'b0, 1 << 30);
        check_stream("restart");

        // Random stream with a flipped code bit every 10th pair
        do_reset();
        src.delete();
        for (int i = 0; i < 1000; i++) src.push_back(1'($urandom_range(1, 0)));
        for (int i = 0; i < 2 + TB_DEPTH; i++) src.push_back(1'b0);
        run_stream(-1, 10, 1'b0, 1'b1, 1 << 30);
        check_stream("random");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
